fp_misc_pipe: RTL and testbench
===============================

// Module: fp_misc_pipe
// PURPOSE
//  Pipelined, parametrised FP non-arithmetic unit: sign injection, min/max, compare,
//  classify and FP<->int moves for both S and D formats, selected per operation.
//  Sits beside the D-extension ALU in the FPU execute stage. Operands arrive over a
//  valid/ready handshake; results leave the same way, in order.
//  Adds NaN-boxing, IEEE invalid-flag (NV) generation and a sticky fflags accumulator.
// PARAMETERS
//  FLEN     64  FP register width (32 or 64); fmt=D is illegal when FLEN=32
//  XLEN     64  integer register width (32 or 64)
//  LATENCY  2   pipeline stages from accept to out_valid (>=1)
// PORTS
//  clk         in   1     clock
//  rst_n       in   1     synchronous active-low reset
//  in_valid    in   1     operation valid
//  in_ready    out  1     unit can accept this cycle
//  op          in   4     0 FSGNJ,1 FSGNJN,2 FSGNJX,3 FMIN,4 FMAX,5 FEQ,6 FLT,7 FLE,8 FCLASS,9 FMV.X,10 FMV.F.X
//  fmt         in   1     0 = single (S), 1 = double (D)
//  rs1,rs2     in   FLEN  FP operands
//  int_rs1     in   XLEN  integer operand (FMV.F.X only)
//  out_valid   out  1     result valid
//  out_ready   in   1     downstream accepts result
//  result      out  FLEN  FP result (ops 0-4,10), else 0
//  int_result  out  XLEN  integer result (ops 5-9), else 0
//  res_is_int  out  1     1 when int_result is the architectural destination
//  res_fflags  out  5     {NV,DZ,OF,UF,NX} for this result; only NV can be set
//  fflags_clr  in   1     clear sticky accumulator
//  fflags      out  5     sticky OR of res_fflags over all retired results
// BEHAVIOUR
//  Reset: all stage valid bits 0; out_valid, result, int_result, res_is_int,
//   res_fflags and fflags are 0. In-flight operations are discarded, not completed.
//  Pipeline: stages 0..LATENCY-1 with valid bits v[k].
//   - Enable: en[LATENCY] = out_ready; en[k] = !v[k] || en[k+1]; in_ready = en[0].
//   - Stage k loads from k-1 (stage 0 from the inputs) when en[k].
//   - Bubbles collapse. Throughput is 1 op/cycle when out_ready is held high.
//   - out_valid = v[LATENCY-1]. All outputs stay stable while out_valid && !out_ready.
//   - Retire = out_valid && out_ready.
//  All computation completes in stage 0; later stages only carry the result.
//  NaN-boxing (FLEN=64, fmt=S):
//   - An input is valid S only if bits[63:32] == all ones; otherwise it is
//     treated as canonical qNaN 0x7FC00000.
//   - S results are written as {32'hFFFFFFFF, s}.
//  Canonical NaN: S 0x7FC00000, D 0x7FF8000000000000. sNaN = NaN with quiet bit 0.
//  FSGNJ/N/X: magnitude of rs1; sign = rs2 / ~rs2 / rs1^rs2. Never raises NV.
//  FMIN/FMAX:
//   - -0 orders below +0.
//   - Exactly one NaN -> return the other operand; both NaN -> canonical NaN.
//   - NV set if either operand is an sNaN.
//  FEQ/FLT/FLE: int_result = {0,bit}; +0 == -0.
//   - Any NaN operand -> bit 0.
//   - FEQ raises NV only on an sNaN; FLT/FLE raise NV on any NaN.
//  FCLASS: 10-bit one-hot, zero-extended to XLEN.
//   - bit0 -inf, 1 -norm, 2 -sub, 3 -0, 4 +0, 5 +sub, 6 +norm, 7 +inf, 8 sNaN, 9 qNaN.
//  FMV.X: S -> sign-extend rs1[31:0] to XLEN, no unboxing check; D -> rs1 (XLEN=64).
//  FMV.F.X: S -> box int_rs1[31:0]; D -> int_rs1.
//  Illegal op/fmt combination: result, int_result and res_fflags = 0; it still
//   occupies a slot and retires normally.
//  fflags update:
//   - On retire: fflags <= (fflags_clr ? 0 : fflags) | res_fflags.
//   - No retire: fflags <= fflags_clr ? 0 : fflags.
// TESTING
//  1. FMIN D: rs1=0, rs2=0x8000000000000000 -> result 0x8000000000000000, res_fflags 0.
//  2. FLT D: rs1=0x7FF8000000000000, rs2=0x3FF0000000000000 -> int_result 0, NV=1,
//     fflags=0x10; then pulse fflags_clr -> fflags=0 next cycle.
//  3. FMAX S: rs1=0x000000003F800000 (bad box), rs2=0xFFFFFFFF40000000
//     -> result 0xFFFFFFFF40000000, NV=0.
//  4. LATENCY=2: 4 back-to-back ops, out_ready low cycles 3-5 -> in_ready falls when
//     pipe full; 4 results in issue order, none lost or duplicated, stable while stalled.
//  5. FCLASS D: 0xFFF0000000000000 -> 0x001; 0x7FF0000000000001 -> 0x100.
//  6. rst_n low with 2 ops in flight -> next cycle out_valid=0, fflags=0, in_ready=1.

Source files
------------

// File: rtl/fp_misc_pipe.sv
// fp_misc_pipe: pipelined FP non-arithmetic unit (sign injection, min/max,
// compare, classify, FP<->int moves) for S and D formats. All computation
// happens ahead of stage 0; the remaining stages only carry the result.
// The unit handles NaN-boxing of S values and raises only the invalid flag (NV).
// A sticky fflags accumulator collects the flags of every retired result.
module fp_misc_pipe #(
  parameter int FLEN    = 64,
  parameter int XLEN    = 64,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic            fmt,
  input  logic [FLEN-1:0] rs1,
  input  logic [FLEN-1:0] rs2,
  input  logic [XLEN-1:0] int_rs1,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] result,
  output logic [XLEN-1:0] int_result,
  output logic            res_is_int,
  output logic [4:0]      res_fflags,
  input  logic            fflags_clr,
  output logic [4:0]      fflags
);

  typedef enum logic [3:0] {
    OP_FSGNJ  = 4'd0,
    OP_FSGNJN = 4'd1,
    OP_FSGNJX = 4'd2,
    OP_FMIN   = 4'd3,
    OP_FMAX   = 4'd4,
    OP_FEQ    = 4'd5,
    OP_FLT    = 4'd6,
    OP_FLE    = 4'd7,
    OP_FCLASS = 4'd8,
    OP_FMV_XF = 4'd9,
    OP_FMV_FX = 4'd10
  } op_e;

  localparam logic [31:0] CANON_S = 32'h7FC0_0000;
  localparam logic [63:0] CANON_D = 64'h7FF8_0000_0000_0000;
  localparam logic [31:0] BOX_HI  = 32'hFFFF_FFFF;

  // Raw IEEE fields of one operand, already selected for the active format.
  typedef struct packed {
    logic sign;
    logic exp_ones;
    logic exp_zero;
    logic man_zero;
    logic quiet;
  } fld_t;

  // Payload carried down the pipeline.
  typedef struct packed {
    logic [FLEN-1:0] result;
    logic [XLEN-1:0] int_result;
    logic            is_int;
    logic [4:0]      flags;
  } stage_t;

  function automatic fld_t decode(input logic [63:0] v, input logic dbl);
    fld_t f;
    if (dbl) begin
      f.sign     = v[63];
      f.exp_ones = &v[62:52];
      f.exp_zero = ~|v[62:52];
      f.man_zero = ~|v[51:0];
      f.quiet    = v[51];
    end else begin
      f.sign     = v[31];
      f.exp_ones = &v[30:23];
      f.exp_zero = ~|v[30:23];
      f.man_zero = ~|v[22:0];
      f.quiet    = v[22];
    end
    return f;
  endfunction

  // 10-bit one-hot class: -inf,-norm,-sub,-0,+0,+sub,+norm,+inf,sNaN,qNaN.
  function automatic logic [9:0] fclass(input fld_t f);
    logic inf, nan, zero, sub, norm;
    inf  = f.exp_ones & f.man_zero;
    nan  = f.exp_ones & ~f.man_zero;
    zero = f.exp_zero & f.man_zero;
    sub  = f.exp_zero & ~f.man_zero;
    norm = ~f.exp_ones & ~f.exp_zero;
    return {nan & f.quiet, nan & ~f.quiet,
            ~f.sign & inf, ~f.sign & norm, ~f.sign & sub, ~f.sign & zero,
            f.sign & zero, f.sign & sub, f.sign & norm, f.sign & inf};
  endfunction

  // Operands widened to 64 bits so S/D decoding is independent of FLEN/XLEN.
  logic [63:0] rs1_x, rs2_x, int_x;
  logic        box1_ok, box2_ok;
  logic [63:0] a, b;
  fld_t        fa, fb;
  logic        a_nan, b_nan, a_snan, b_snan, both_zero;
  logic [63:0] mag_a, mag_b;
  logic        lt_ord;

  assign rs1_x   = 64'(rs1);
  assign rs2_x   = 64'(rs2);
  assign int_x   = 64'(int_rs1);
  // With FLEN=32 there is no box to check; S values fill the register.
  assign box1_ok = (FLEN == 32) || (&rs1_x[63:32]);
  assign box2_ok = (FLEN == 32) || (&rs2_x[63:32]);

  // Canonical operands: S values sit in the low word, badly boxed ones become qNaN.
  always_comb begin
    a = fmt ? rs1_x : {32'b0, (box1_ok ? rs1_x[31:0] : CANON_S)};
    b = fmt ? rs2_x : {32'b0, (box2_ok ? rs2_x[31:0] : CANON_S)};
  end

  // Operand classification and total ordering shared by min/max and compares.
  always_comb begin
    fa        = decode(a, fmt);
    fb        = decode(b, fmt);
    a_nan     = fa.exp_ones & ~fa.man_zero;
    b_nan     = fb.exp_ones & ~fb.man_zero;
    a_snan    = a_nan & ~fa.quiet;
    b_snan    = b_nan & ~fb.quiet;
    both_zero = fa.exp_zero & fa.man_zero & fb.exp_zero & fb.man_zero;
    mag_a     = fmt ? {1'b0, a[62:0]} : {33'b0, a[30:0]};
    mag_b     = fmt ? {1'b0, b[62:0]} : {33'b0, b[30:0]};
    // Sign-magnitude order in which -0 sorts below +0; not meaningful for NaNs.
    if (fa.sign != fb.sign) lt_ord = fa.sign;
    else if (fa.sign)       lt_ord = mag_b < mag_a;
    else                    lt_ord = mag_a < mag_b;
  end

  logic [63:0] res64, ires64, minmax;
  logic        sgn, is_int, nv, legal, feq, flt;
  stage_t      stage_d;

  // Per-operation result selection feeding stage 0.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    res64   = '0;
    ires64  = '0;
    minmax  = '0;
    sgn     = 1'b0;
    is_int  = 1'b0;
    nv      = 1'b0;
    legal   = !(fmt && (FLEN == 32));
    feq     = !(a_nan || b_nan) && (both_zero || (a == b));
    flt     = !(a_nan || b_nan) && !both_zero && lt_ord;

    case (op)
      OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
        if (op == OP_FSGNJ)       sgn = fb.sign;
        else if (op == OP_FSGNJN) sgn = ~fb.sign;
        else                      sgn = fa.sign ^ fb.sign;
        res64 = fmt ? {sgn, a[62:0]} : {BOX_HI, sgn, a[30:0]};
      end
      OP_FMIN, OP_FMAX: begin
        if (a_nan && b_nan)  minmax = fmt ? CANON_D : {32'b0, CANON_S};
        else if (a_nan)      minmax = b;
        else if (b_nan)      minmax = a;
        else if (op == OP_FMIN) minmax = lt_ord ? a : b;
        else                    minmax = lt_ord ? b : a;
        res64 = fmt ? minmax : {BOX_HI, minmax[31:0]};
        nv    = a_snan | b_snan;
      end
      OP_FEQ: begin
        is_int = 1'b1;
        ires64 = {63'b0, feq};
        nv     = a_snan | b_snan;
      end
      OP_FLT, OP_FLE: begin
        is_int = 1'b1;
        ires64 = {63'b0, (op == OP_FLT) ? flt : (flt | feq)};
        nv     = a_nan | b_nan;
      end
      OP_FCLASS: begin
        is_int = 1'b1;
        ires64 = {54'b0, fclass(fa)};
      end
      OP_FMV_XF: begin
        // Raw bit move: the S form ignores boxing and sign-extends the low word.
        is_int = 1'b1;
        ires64 = fmt ? rs1_x : {{32{rs1_x[31]}}, rs1_x[31:0]};
        if (fmt && (XLEN == 32)) legal = 1'b0;
      end
      OP_FMV_FX: begin
        res64 = fmt ? int_x : {BOX_HI, int_x[31:0]};
        if (fmt && (XLEN == 32)) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase

    // Illegal combinations still occupy a slot but carry an all-zero result.
    if (!legal) begin
      res64  = '0;
      ires64 = '0;
      is_int = 1'b0;
      nv     = 1'b0;
    end

    stage_d.result     = FLEN'(res64);
    stage_d.int_result = XLEN'(ires64);
    stage_d.is_int     = is_int;
    stage_d.flags      = {nv, 4'b0};
  end

  stage_t             stage_q [LATENCY];
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] en;
  logic               retire;
  logic [4:0]         fflags_d, fflags_q;

  // Stage enables: a stage may load when it is empty or its successor moves on.
  always_comb begin
    logic ok;
    ok = out_ready;
    en = '0;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      ok    = !v_q[k] || ok;
      en[k] = ok;
    end
  end

  assign in_ready = en[0];

  // Pipeline valid bits and payload; bubbles collapse as later stages drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the payload is reset along with the valid bits because the last
      // stage drives the outputs directly and they must read zero after reset.
      v_q <= '0;
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's
      // old value, so the loop order does not matter.
      if (en[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) stage_q[0] <= stage_d;
      end
      for (int k = 1; k < LATENCY; k++) begin
        if (en[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) stage_q[k] <= stage_q[k-1];
        end
      end
    end
  end

  assign out_valid  = v_q[LATENCY-1];
  assign result     = stage_q[LATENCY-1].result;
  assign int_result = stage_q[LATENCY-1].int_result;
  assign res_is_int = stage_q[LATENCY-1].is_int;
  assign res_fflags = stage_q[LATENCY-1].flags;
  assign retire     = out_valid && out_ready;

  // Sticky flags: the clear applies first so a retiring result survives it.
  always_comb begin
    fflags_d = fflags_clr ? 5'b0 : fflags_q;
    if (retire) fflags_d = fflags_d | res_fflags;
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) fflags_q <= '0;
    else        fflags_q <= fflags_d;
  end

  assign fflags = fflags_q;

endmodule

// File: tb/tb_fp_misc_pipe.sv
// Scoreboard bench for fp_misc_pipe (FLEN=64, XLEN=64, LATENCY=2).
// A driver pushes hand-computed expectations as operations are accepted;
// an independent monitor pops and compares on every retire and checks that
// outputs hold steady while stalled.
module tb_fp_misc_pipe;

  localparam logic [3:0] FSGNJ = 4'd0, FSGNJN = 4'd1, FSGNJX = 4'd2, FMIN = 4'd3,
                         FMAX = 4'd4, FEQ = 4'd5, FLT = 4'd6, FLE = 4'd7,
                         FCLASS = 4'd8, FMVXF = 4'd9, FMVFX = 4'd10;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, fmt, out_valid, out_ready;
  logic [3:0]  op;
  logic [63:0] rs1, rs2, int_rs1, result, int_result;
  logic        res_is_int, fflags_clr;
  logic [4:0]  res_fflags, fflags;

  fp_misc_pipe #(.FLEN(64), .XLEN(64), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .fmt(fmt), .rs1(rs1), .rs2(rs2), .int_rs1(int_rs1),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .int_result(int_result), .res_is_int(res_is_int), .res_fflags(res_fflags),
    .fflags_clr(fflags_clr), .fflags(fflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [63:0] ires;
    logic        is_int;
    logic [4:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   retired = 0;
  logic saw_backpressure = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one operation until accepted, then record its expected result.
  task automatic issue(input string name, input logic [3:0] o, input logic f,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] ir,
                       input logic [63:0] er, input logic [63:0] eir,
                       input logic eis, input logic [4:0] efl);
    exp_t e;
    int   waits;
    @(negedge clk);
    op = o; fmt = f; rs1 = a; rs2 = b; int_rs1 = ir; in_valid = 1'b1;
    #1;
    waits = 0;
    while (!in_ready && waits < 50) begin
      saw_backpressure = 1'b1;
      waits++;
      @(negedge clk);
      #1;
    end
    if (!in_ready) begin
      check({name, ".accept_timeout"}, 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      e.name = name; e.res = er; e.ires = eir; e.is_int = eis; e.fl = efl;
      sb.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // Monitor: compares on every retire, checks stability across stalled cycles.
  initial begin
    exp_t        e;
    logic        held_v;
    logic [63:0] h_res, h_ires;
    logic [4:0]  h_fl;
    held_v = 1'b0;
    h_res = '0; h_ires = '0; h_fl = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held_v = 1'b0;
      end else if (out_valid) begin
        if (held_v) begin
          check("stall_stable.result", result, h_res);
          check("stall_stable.int_result", int_result, h_ires);
          check("stall_stable.fflags", 64'(res_fflags), 64'(h_fl));
        end
        if (!out_ready) begin
          held_v = 1'b1;
          h_res = result; h_ires = int_result; h_fl = res_fflags;
        end else begin
          held_v = 1'b0;
          retired++;
          if (sb.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check({e.name, ".result"}, result, e.res);
            check({e.name, ".int_result"}, int_result, e.ires);
            check({e.name, ".res_is_int"}, 64'(res_is_int), 64'(e.is_int));
            check({e.name, ".res_fflags"}, 64'(res_fflags), 64'(e.fl));
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int retired_before;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;
    op = '0; fmt = 1'b0; rs1 = '0; rs2 = '0; int_rs1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.result", result, 64'd0);
    check("reset.int_result", int_result, 64'd0);
    check("reset.res_is_int", 64'(res_is_int), 64'd0);
    check("reset.res_fflags", 64'(res_fflags), 64'd0);
    check("reset.fflags", 64'(fflags), 64'd0);
    rst_n = 1'b1;

    // -0 orders below +0; qNaN in FLT raises NV and the sticky flag, then clear.
    issue("fmin_d_zeros", FMIN, 1'b1, 64'h0, 64'h8000000000000000, 64'h0,
          64'h8000000000000000, 64'h0, 1'b0, 5'h00);
    issue("flt_d_qnan", FLT, 1'b1, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h0,
          64'h0, 64'h0, 1'b1, 5'h10);
    drain();
    @(negedge clk);
    check("fflags_after_flt", 64'(fflags), 64'h10);
    fflags_clr = 1'b1;
    @(posedge clk);
    #1;
    check("fflags_cleared", 64'(fflags), 64'h0);
    fflags_clr = 1'b0;

    // Directed vectors, back to back.
    issue("fmax_s_badbox", FMAX, 1'b0, 64'h000000003F800000, 64'hFFFFFFFF40000000, 64'h0,
          64'hFFFFFFFF40000000, 64'h0, 1'b0, 5'h00);
    issue("fclass_d_neginf", FCLASS, 1'b1, 64'hFFF0000000000000, 64'h0, 64'h0,
          64'h0, 64'h001, 1'b1, 5'h00);
    issue("fclass_d_snan", FCLASS, 1'b1, 64'h7FF0000000000001, 64'h0, 64'h0,
          64'h0, 64'h100, 1'b1, 5'h00);
    issue("fclass_d_negsub", FCLASS, 1'b1, 64'h8000000000000001, 64'h0, 64'h0,
          64'h0, 64'h004, 1'b1, 5'h00);
    issue("fclass_s_posinf", FCLASS, 1'b0, 64'hFFFFFFFF7F800000, 64'h0, 64'h0,
          64'h0, 64'h080, 1'b1, 5'h00);
    issue("fclass_s_badbox", FCLASS, 1'b0, 64'h0000000000000001, 64'h0, 64'h0,
          64'h0, 64'h200, 1'b1, 5'h00);
    issue("fsgnjn_s", FSGNJN, 1'b0, 64'hFFFFFFFF3F800000, 64'hFFFFFFFF3F800000, 64'h0,
          64'hFFFFFFFFBF800000, 64'h0, 1'b0, 5'h00);
    issue("fsgnjx_d", FSGNJX, 1'b1, 64'hC000000000000000, 64'h8000000000000000, 64'h0,
          64'h4000000000000000, 64'h0, 1'b0, 5'h00);
    issue("feq_s_pm_zero", FEQ, 1'b0, 64'hFFFFFFFF00000000, 64'hFFFFFFFF80000000, 64'h0,
          64'h0, 64'h1, 1'b1, 5'h00);
    issue("feq_d_snan", FEQ, 1'b1, 64'h7FF0000000000001, 64'h0, 64'h0,
          64'h0, 64'h0, 1'b1, 5'h10);
    issue("fle_d_equal", FLE, 1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0,
          64'h0, 64'h1, 1'b1, 5'h00);
    issue("flt_s_neg", FLT, 1'b0, 64'hFFFFFFFFBF800000, 64'hFFFFFFFF3F800000, 64'h0,
          64'h0, 64'h1, 1'b1, 5'h00);
    issue("fmin_s_both_nan", FMIN, 1'b0, 64'hFFFFFFFF7FC00000, 64'hFFFFFFFF7F800001, 64'h0,
          64'hFFFFFFFF7FC00000, 64'h0, 1'b0, 5'h10);
    issue("fmax_d_one_nan", FMAX, 1'b1, 64'hBFF0000000000000, 64'h7FF8000000000000, 64'h0,
          64'hBFF0000000000000, 64'h0, 1'b0, 5'h00);
    issue("fmvxf_s", FMVXF, 1'b0, 64'h0000000080000001, 64'h0, 64'h0,
          64'h0, 64'hFFFFFFFF80000001, 1'b1, 5'h00);
    issue("fmvxf_d", FMVXF, 1'b1, 64'hDEADBEEF01234567, 64'h0, 64'h0,
          64'h0, 64'hDEADBEEF01234567, 1'b1, 5'h00);
    issue("fmvfx_s", FMVFX, 1'b0, 64'h0, 64'h0, 64'h123456789ABCDEF0,
          64'hFFFFFFFF9ABCDEF0, 64'h0, 1'b0, 5'h00);
    issue("fmvfx_d", FMVFX, 1'b1, 64'h0, 64'h0, 64'h0123456789ABCDEF,
          64'h0123456789ABCDEF, 64'h0, 1'b0, 5'h00);
    issue("illegal_op", 4'd11, 1'b0, 64'h7FF0000000000001, 64'h1234, 64'h5678,
          64'h0, 64'h0, 1'b0, 5'h00);
    drain();
    @(negedge clk);
    check("fflags_sticky", 64'(fflags), 64'h10);

    // Four back-to-back ops with out_ready low for cycles 3-5 of the burst.
    retired_before = retired;
    saw_backpressure = 1'b0;
    fork
      begin
        for (int k = 1; k <= 4; k++)
          issue($sformatf("burst_%0d", k), FSGNJ, 1'b1, 64'h3FF0000000000000 + 64'(k),
                64'h0, 64'h0, 64'h3FF0000000000000 + 64'(k), 64'h0, 1'b0, 5'h00);
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("burst.in_ready_fell", 64'(saw_backpressure), 64'd1);
    check("burst.retired_count", 64'(retired - retired_before), 64'd4);

    // Reset with two operations in flight discards them.
    @(negedge clk);
    out_ready = 1'b0;
    issue("inflight_1", FLT, 1'b1, 64'h7FF8000000000000, 64'h0, 64'h0,
          64'h0, 64'h0, 1'b1, 5'h10);
    issue("inflight_2", FLT, 1'b1, 64'h7FF8000000000000, 64'h0, 64'h0,
          64'h0, 64'h0, 1'b1, 5'h10);
    @(negedge clk);
    check("inflight.out_valid_before_reset", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    check("rst_inflight.out_valid", 64'(out_valid), 64'd0);
    check("rst_inflight.fflags", 64'(fflags), 64'd0);
    check("rst_inflight.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset.out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
